// File: rtl/alu_iter_exec_pkg.sv
// Shared definitions for the iterative execute-stage ALU.
// Holds the 4-bit ALU opcode codes, the FSM state codes (also used by the
// bench to probe state) and a helper that classifies the shift opcodes.
package alu_iter_exec_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_ADDU = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_SUBU = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_LSL  = 4'h7;
   localparam logic [3:0] OP_LSR  = 4'h8;
   localparam logic [3:0] OP_ASR  = 4'h9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_e;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift step for the iterative shifter.
// Ports:
//   shreg   in   WIDTH  current shift register value
//   opcode  in   4      OP_LSL / OP_LSR / OP_ASR select direction and fill
//   shifted out  WIDTH  shreg moved by one bit (unchanged for other opcodes)
module alu_shift_step
   import alu_iter_exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] shreg,
   input  logic [3:0]       opcode,
   output logic [WIDTH-1:0] shifted
);

   always_comb begin
      shifted = shreg;
      case (opcode)
         OP_LSL:  shifted = {shreg[WIDTH-2:0], 1'b0};
         OP_LSR:  shifted = {1'b0, shreg[WIDTH-1:1]};
         OP_ASR:  shifted = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
         default: shifted = shreg;
      endcase
   end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with single-cycle logic/arithmetic and a one-bit-per-cycle
// iterative shifter. Valid/ready handshake on both the request and result side.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    request handshake (in_ready high only in IDLE)
//   opcode, a, b, shamt    request; b is the shift source, shamt the distance
//   out_valid / out_ready  result handshake
//   result, zero,          registered result and flags, held while
//   overflow, illegal      out_valid && !out_ready
//
// state    | meaning
// ST_IDLE  | waiting for a request, in_ready=1
// ST_SHIFT | shifting shreg one bit per cycle, cnt bits remaining
// ST_DONE  | result valid, waiting for out_ready
module alu_iter_exec
   import alu_iter_exec_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         opcode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               overflow,
   output logic               illegal
);

   alu_state_e         state;
   logic [WIDTH-1:0]   shreg;
   logic [WIDTH-1:0]   shreg_nxt;
   logic [SHAMT_W-1:0] cnt;
   logic [3:0]         op_q;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf;
   logic               alu_ill;

   alu_shift_step #(.WIDTH(WIDTH)) u_shift_step (
      .shreg   (shreg),
      .opcode  (op_q),
      .shifted (shreg_nxt)
   );

   // Single-cycle path; shift opcodes land here only when shamt is zero.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_res = a + b;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_ADDU: alu_res = a + b;
         OP_SUB: begin
            alu_res = a - b;
            // b is effectively inverted for subtraction, so signs must differ
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUBU: alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_LSL, OP_LSR, OP_ASR: alu_res = b;
         default: alu_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
         cnt       <= '0;
         shreg     <= '0;
         op_q      <= OP_ADD;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (is_shift(opcode) && (shamt != '0)) begin
                     shreg <= b;
                     cnt   <= shamt;
                     op_q  <= opcode;
                     state <= ST_SHIFT;
                  end else begin
                     result    <= alu_res;
                     zero      <= (alu_res == '0);
                     overflow  <= alu_ovf;
                     illegal   <= alu_ill;
                     out_valid <= 1'b1;
                     state     <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               shreg <= shreg_nxt;
               cnt   <= cnt - 1'b1;
               if (cnt == SHAMT_W'(1)) begin
                  result    <= shreg_nxt;
                  zero      <= (shreg_nxt == '0);
                  overflow  <= 1'b0;
                  illegal   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               // in_ready only rises on the next edge, so no accept can
               // coincide with the output handshake.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_iter_exec;
   import alu_iter_exec_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        illegal;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_iter_exec #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .illegal   (illegal)
   );

   // Reference model from the arithmetic definition of each opcode.
   function automatic void model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [4:0] sh, output logic [31:0] r, output logic ov,
                                 output logic il, output int lat);
      longint sa = longint'($signed(av));
      longint sb = longint'($signed(bv));
      longint s;
      r = 32'd0; ov = 1'b0; il = 1'b0; lat = 1;
      case (op)
         OP_ADD:  begin r = av + bv; s = sa + sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         OP_ADDU: r = av + bv;
         OP_SUB:  begin r = av - bv; s = sa - sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         OP_SUBU: r = av - bv;
         OP_AND:  r = av & bv;
         OP_OR:   r = av | bv;
         OP_XOR:  r = av ^ bv;
         OP_LSL:  begin r = bv << sh; lat = int'(sh) + 1; end
         OP_LSR:  begin r = bv >> sh; lat = int'(sh) + 1; end
         OP_ASR:  begin r = $unsigned($signed(bv) >>> sh); lat = int'(sh) + 1; end
         default: il = 1'b1;
      endcase
   endfunction

   // Drives one request, measures latency, captures outputs, then handshakes
   // after holding out_ready low for 'hold' extra cycles.
   task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, input int hold, output int lat,
                         output logic [31:0] r, output logic z, output logic ov, output logic il);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL run_op_in_ready: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1; opcode = op; a = av; b = bv; shamt = sh; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      opcode = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      r = result; z = zero; ov = overflow; il = illegal;
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; opcode = OP_ADD; a = 32'd3; b = 32'd4; shamt = 5'd0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
      n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", zero); end
      n_checks++; if (overflow !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_flags: ovf=%b ill=%b want 0 0", overflow, illegal); end
      n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, ST_IDLE); end
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_add_overflow;
      int lat; logic [31:0] r; logic z, ov, il;
      run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, lat, r, z, ov, il);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
      n_checks++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result: got %h want 80000000", r); end
      n_checks++; if (ov !== 1'b1 || z !== 1'b0) begin n_fail++; $display("FAIL add_flags: ovf=%b zero=%b want 1 0", ov, z); end
      run_op(OP_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, lat, r, z, ov, il);
      n_checks++; if (r !== 32'h8000_0000 || ov !== 1'b0) begin n_fail++; $display("FAIL addu: result=%h ovf=%b want 80000000 0", r, ov); end
   endtask

   task automatic test_sub_xor;
      int lat; logic [31:0] r; logic z, ov, il;
      run_op(OP_SUB, 32'd5, 32'd5, 5'd3, 0, lat, r, z, ov, il);
      n_checks++; if (r !== 32'd0 || z !== 1'b1 || ov !== 1'b0) begin n_fail++; $display("FAIL sub_zero: result=%h zero=%b ovf=%b want 0 1 0", r, z, ov); end
      run_op(OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 0, lat, r, z, ov, il);
      n_checks++; if (r !== 32'h7FFF_FFFF || ov !== 1'b1) begin n_fail++; $display("FAIL sub_ovf: result=%h ovf=%b want 7fffffff 1", r, ov); end
      run_op(OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0, 0, lat, r, z, ov, il);
      n_checks++; if (r !== 32'h0F0F_F0F0 || lat !== 1) begin n_fail++; $display("FAIL xor: result=%h lat=%0d want 0f0ff0f0 1", r, lat); end
   endtask

   task automatic test_shifts;
      int lat; logic [31:0] r; logic z, ov, il;
      run_op(OP_ASR, 32'h8000_0000, 32'h8000_0000, 5'd31, 0, lat, r, z, ov, il);
      n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL asr31_latency: got %0d want 32", lat); end
      n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL asr31_result: got %h want ffffffff", r); end
      run_op(OP_LSR, 32'd0, 32'h8000_0000, 5'd31, 0, lat, r, z, ov, il);
      n_checks++; if (r !== 32'h0000_0001 || lat !== 32) begin n_fail++; $display("FAIL lsr31: result=%h lat=%0d want 00000001 32", r, lat); end
      run_op(OP_LSL, 32'd0, 32'd1, 5'd0, 0, lat, r, z, ov, il);
      n_checks++; if (r !== 32'd1 || lat !== 1) begin n_fail++; $display("FAIL lsl0: result=%h lat=%0d want 1 1", r, lat); end
      run_op(OP_LSL, 32'd0, 32'h8000_0000, 5'd1, 0, lat, r, z, ov, il);
      n_checks++; if (r !== 32'd0 || z !== 1'b1 || lat !== 2) begin n_fail++; $display("FAIL lsl1_zero: result=%h zero=%b lat=%0d want 0 1 2", r, z, lat); end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_or  = 32'h1234_0000 | 32'h0000_5678;
      logic [31:0] exp_xor = 32'hAAAA_5555 ^ 32'hFFFF_0000;
      @(negedge clk);
      in_valid = 1'b1; opcode = OP_OR; a = 32'h1234_0000; b = 32'h0000_5678; shamt = 5'd0; out_ready = 1'b0;
      @(negedge clk);
      opcode = OP_XOR; a = 32'hAAAA_5555; b = 32'hFFFF_0000;
      n_checks++; if (out_valid !== 1'b1 || result !== exp_or) begin n_fail++; $display("FAIL bp_first: out_valid=%b result=%h want 1 %h", out_valid, result, exp_or); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_or || zero !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b result=%h want 1 0 %h", i, out_valid, in_ready, result, exp_or);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_handshake: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || result !== exp_xor) begin n_fail++; $display("FAIL bp_second: out_valid=%b result=%h want 1 %h", out_valid, result, exp_xor); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_shift;
      int lat; logic [31:0] r; logic z, ov, il;
      logic seen = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; opcode = OP_LSL; a = 32'd0; b = 32'h0000_0003; shamt = 5'd20; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      seen = seen | out_valid;
      repeat (6) begin @(negedge clk); seen = seen | out_valid; end
      rst = 1'b1;
      @(negedge clk);
      seen = seen | out_valid;
      rst = 1'b0; out_ready = 1'b0;
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midshift_pulse: out_valid seen=%b want 0", seen); end
      n_checks++;
      if (in_ready !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || dut.state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL midshift_reset: in_ready=%b result=%h zero=%b state=%0d want 1 0 1 %0d", in_ready, result, zero, dut.state, ST_IDLE);
      end
      run_op(4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, 1, lat, r, z, ov, il);
      n_checks++;
      if (il !== 1'b1 || r !== 32'd0 || z !== 1'b1 || ov !== 1'b0 || lat !== 1) begin
         n_fail++;
         $display("FAIL illegal_op: ill=%b result=%h zero=%b ovf=%b lat=%0d want 1 0 1 0 1", il, r, z, ov, lat);
      end
   endtask

   task automatic test_random;
      int lat, exp_lat; logic [31:0] r, er, av, bv; logic z, ov, il, eov, eil;
      logic [3:0] op; logic [4:0] sh;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         av = $urandom; bv = $urandom;
         if (i % 4 == 0) bv = 32'd0;
         sh = 5'($urandom_range(0, 31));
         model(op, av, bv, sh, er, eov, eil, exp_lat);
         run_op(op, av, bv, sh, int'($urandom_range(0, 2)), lat, r, z, ov, il);
         n_checks++;
         if (r !== er || z !== (er == 32'd0) || ov !== eov || il !== eil || lat !== exp_lat) begin
            n_fail++;
            $display("FAIL rand[%0d] op=%h a=%h b=%h sh=%0d: got r=%h z=%b ov=%b il=%b lat=%0d want r=%h z=%b ov=%b il=%b lat=%0d",
                     i, op, av, bv, sh, r, z, ov, il, lat, er, (er == 32'd0), eov, eil, exp_lat);
         end
         n_checks++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drop[%0d]: out_valid=%b want 0", i, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_sub_xor();
      test_shifts();
      test_backpressure();
      test_reset_mid_shift();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
